// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per clock,
// then a sign-fix step. Optional macro DIVIDER_REMAINDER_EN keeps the remainder output.
module signed_seq_divider #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0]   LAST_CNT = CW'(SIZE - 1);
  localparam logic [CW-1:0]   ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] ZERO_W   = {SIZE{1'b0}};
  localparam logic [SIZE-1:0] ONE_W    = {{(SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [SIZE-1:0] neg_if(input logic [SIZE-1:0] v, input logic neg);
    if (neg) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  state_t          state_q, state_d;
  logic [SIZE-1:0] acc_q, acc_d;       // dividend magnitude, becomes quotient magnitude
  logic [SIZE-1:0] dsr_q, dsr_d;
  logic [SIZE:0]   prem_q, prem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_dvd_q, neg_dvd_d;
  logic            neg_dsr_q, neg_dsr_d;
  logic            zero_q, zero_d;
  logic [SIZE-1:0] quot_q, quot_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SIZE+1:0] shift_rem;
  logic [SIZE+1:0] trial;

  assign shift_rem = {prem_q, acc_q[SIZE-1]};
  assign trial     = shift_rem - {2'b00, dsr_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (divisor == ZERO_W) ? S_FIX : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs, registered below
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
  end

  // Datapath next-state: capture, iterate, sign-fix
  always_comb begin
    acc_d     = acc_q;
    dsr_d     = dsr_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    neg_dvd_d = neg_dvd_q;
    neg_dsr_d = neg_dsr_q;
    zero_d    = zero_q;
    quot_d    = quot_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = neg_if(dividend, dividend[SIZE-1]);
          dsr_d     = neg_if(divisor, divisor[SIZE-1]);
          neg_dvd_d = dividend[SIZE-1];
          neg_dsr_d = divisor[SIZE-1];
          prem_d    = {(SIZE+1){1'b0}};
          cnt_d     = {CW{1'b0}};
          zero_d    = (divisor == ZERO_W);
          dbz_d     = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        if (trial[SIZE+1] == 1'b0) begin
          prem_d = trial[SIZE:0];
          acc_d  = {acc_q[SIZE-2:0], 1'b1};
        end else begin
          prem_d = shift_rem[SIZE:0];
          acc_d  = {acc_q[SIZE-2:0], 1'b0};
        end
        cnt_d = cnt_q + ONE_C;
      end
      S_FIX: begin
        if (zero_q) begin
          quot_d = ~ZERO_W;
        end else begin
          quot_d = neg_if(acc_q, neg_dvd_q ^ neg_dsr_q);
        end
        dbz_d = zero_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= ZERO_W;
      dsr_q     <= ZERO_W;
      prem_q    <= {(SIZE+1){1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_dvd_q <= 1'b0;
      neg_dsr_q <= 1'b0;
      zero_q    <= 1'b0;
      quot_q    <= ZERO_W;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dsr_q     <= dsr_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dsr_q <= neg_dsr_d;
      zero_q    <= zero_d;
      quot_q    <= quot_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef DIVIDER_REMAINDER_EN
  logic [SIZE-1:0] rem_q, rem_d;

  // Remainder takes the dividend's sign; on divide-by-zero it echoes the dividend
  always_comb begin
    rem_d = rem_q;
    if (state_q == S_FIX) begin
      if (zero_q) begin
        rem_d = neg_if(acc_q, neg_dvd_q);
      end else begin
        rem_d = neg_if(prem_q[SIZE-1:0], neg_dvd_q);
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Remainder register
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= ZERO_W;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign remainder = rem_q;
`else
  assign remainder = ZERO_W;
`endif

  assign quotient    = quot_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed self-checking bench for signed_seq_divider (SIZE=32).
module tb_signed_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  signed_seq_divider #(.SIZE(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx(input logic [31:0] r);
`ifdef DIVIDER_REMAINDER_EN
    return r;
`else
    return 32'd0;
`endif
  endfunction

  // Issue one operation; returns edges from acceptance to done and busy cycles seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int elat);
    int lat, bc;
    do_op(a, b, lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, rx(er));
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, bc, n, dcnt;
    rst = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // 100 / 7 with latency and busy length
    do_op(32'd100, 32'd7, lat, bc);
    check("p_lat", 32'(lat), 32'd33);
    check("p_busy", 32'(bc), 32'd33);
    check("p_q", quotient, 32'd14);
    check("p_r", remainder, rx(32'd2));
    @(posedge clk); #1;
    check("p_done_pulse", {31'd0, done}, 32'd0);

    op_check("nn", 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
    op_check("pn", 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33);
    op_check("mm", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33);
    op_check("min", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,       1'b0, 33);
    op_check("max", 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,       1'b0, 33);
    op_check("dz",  32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    op_check("after_dz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Start pulsed mid-operation is ignored
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 10;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_lat", 32'(n), 32'd33);
    check("ign_q", quotient, 32'd14);
    check("ign_r", remainder, rx(32'd2));

    // Start held while done is high is accepted back-to-back
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat", 32'(n), 32'd33);
    check("b2b_q", quotient, 32'd10);
    check("b2b_r", remainder, rx(32'd0));

    // Reset mid-operation abandons it
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_q", quotient, 32'd0);
    check("mrst_r", remainder, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("mrst_no_done", 32'(dcnt), 32'd0);
    op_check("fresh", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    // Reset and start on the same edge: request dropped
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    check("rs_busy0", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rs_busy1", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Multi-cycle signed integer divider for the fully-connected datapath, the inverse of the combinational Booth multiplier. It normalises accumulated dot products, e.g. average pooling and fixed-point rescale. Start/done handshake. One quotient bit per clock by restoring division on operand magnitudes, then a sign-fix step gives C-style truncating results.

## Interface
- `SIZE`, default 32: operand and result width in bits, two's complement; legal range 4..64.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `dividend` in SIZE: signed dividend; captured on the accepting edge.
- `divisor` in SIZE: signed divisor; captured on the accepting edge.
- `quotient` out SIZE: signed quotient; registered.
- `remainder` out SIZE: signed remainder; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; results valid from this cycle.
- `div_by_zero` out 1: sticky per operation; set with `done` when the divisor is 0.

## Operation
- States:
  - IDLE: accept requests.
  - CALC: iterate.
  - FIX: apply signs and register results.
- IDLE & `start`:
  - capture `|dividend|` and `|divisor|` as SIZE-bit unsigned values, so |MIN| = 2^(SIZE-1) fits.
  - capture the sign bits.
  - clear the SIZE+1-bit partial remainder and the iteration counter.
- IDLE -> CALC when divisor != 0. IDLE -> FIX with the zero flag set when divisor == 0.
- CALC, each cycle:
  - shift {partial remainder, dividend magnitude} left by 1.
  - trial-subtract the divisor magnitude from the partial remainder.
  - if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - exit to FIX after exactly SIZE iterations.
- FIX:
  - negate the quotient iff the operand signs differ.
  - negate the remainder iff the dividend is negative.
  - register both outputs, pulse `done`, return to IDLE.
- Divide by zero: `quotient` = all ones (-1), `remainder` = `dividend`, `div_by_zero` = 1.
- MIN / -1: the quotient magnitude 2^(SIZE-1) truncates to SIZE bits, so `quotient` = MIN and `remainder` = 0. This is not flagged.
- Invariant for non-zero divisor: quotient*divisor + remainder == dividend (mod 2^SIZE), and |remainder| < |divisor|.
- `start` while `busy` is ignored. The operation in flight is unaffected, and the request is not queued.
- `quotient`, `remainder` and `div_by_zero` hold their values until the FIX of the next operation. `div_by_zero` is cleared on each accepted start.

## Timing
- Edge E0 samples `start` in IDLE. `busy` is high from the cycle after E0.
- Non-zero divisor: CALC occupies edges E1..E_SIZE. FIX is registered at E_(SIZE+1).
  - `done` is high for exactly one cycle, E_(SIZE+1) to E_(SIZE+2).
  - Latency is SIZE+1 edges; 33 for SIZE=32.
- Zero divisor: FIX is registered at E1, so `done` is high from E1 to E2. Latency is 1 edge.
- `busy` falls in the same cycle `done` rises. Back-to-back operation is allowed: `start` held high while `done` is high is accepted at that edge.
- Reset values: `quotient` = 0, `remainder` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, state = IDLE.
- `rst` mid-operation: abandon the operation at that edge and force all reset values. No `done` is produced.
- `rst` and `start` on the same edge: reset wins and the request is dropped.

## Configuration
- `DIVIDER_REMAINDER_EN`:
  - Defined: `remainder` carries the sign-corrected partial remainder as specified above.
  - Undefined: the remainder register and its negation logic are removed. `remainder` is tied to 0 permanently. Quotient, flags and timing are unchanged.

## Test plan
SIZE=32 and `DIVIDER_REMAINDER_EN` defined unless noted.
- 100 / 7 -> `quotient` 14, `remainder` 2. `done` is a single pulse exactly 33 edges after start. `busy` is high for 33 cycles.
- Sign cases:
  - -100 / 7 -> -14 r -2.
  - 100 / -7 -> -14 r 2.
  - -100 / -7 -> 14 r -2.
  - With the macro undefined, `remainder` reads 0 in all three.
- Boundary operands:
  - 0x80000000 / -1 -> `quotient` 0x80000000, `remainder` 0, `div_by_zero` 0.
  - 0x7FFFFFFF / 1 -> 0x7FFFFFFF r 0.
- 5 / 0 -> `quotient` 0xFFFFFFFF, `remainder` 5, `div_by_zero` 1, `done` 1 edge after start. A following 9 / 3 -> 3 r 0 with `div_by_zero` cleared.
- Pulse `start` with 50 / 5 at cycle 10 of a running 100 / 7 -> the second request is ignored and the result is 14 r 2. Then hold `start` during `done` with 50 / 5 -> accepted, giving 10 r 0 33 edges later.
- Assert `rst` at cycle 15 of 1000 / 3 -> the next cycle shows all outputs 0 and `busy` 0, and no `done` follows. A fresh 1000 / 3 -> 333 r 1.
